// File: rtl/input_conditioner_pkg.sv
// Shared constants for the vending-machine input conditioner: channel map and debounce default.
package input_conditioner_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;
  localparam int unsigned NUM_CHANNELS            = 9;

  // Channel indices double as arbitration priority: lower index wins.
  localparam int unsigned CH_REFUND = 0;
  localparam int unsigned CH_BUY3   = 1;
  localparam int unsigned CH_BUY2   = 2;
  localparam int unsigned CH_BUY1   = 3;
  localparam int unsigned CH_BUY0   = 4;
  localparam int unsigned CH_MONEY3 = 5;
  localparam int unsigned CH_MONEY2 = 6;
  localparam int unsigned CH_MONEY1 = 7;
  localparam int unsigned CH_MONEY0 = 8;

  function automatic logic [NUM_CHANNELS-1:0] first_pending(input logic [NUM_CHANNELS-1:0] req);
    logic [NUM_CHANNELS-1:0] grant;
    grant = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (req[i] && (grant == '0)) grant[i] = 1'b1;
    end
    return grant;
  endfunction

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// One input channel: two-flop synchronizer, saturating stability counter, debounced level and
// a rise strobe that is high during the cycle whose closing edge flips the level 0->1.
module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic rise
);

  localparam int unsigned    CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;

  always_comb begin
    sync_d  = {sync_q[0], raw};
    cnt_d   = '0;
    level_d = level_q;
    rise    = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = ~level_q;
        rise    = ~level_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Debounces coin/button/refund inputs and issues accepted presses one at a time, by fixed
// priority, as registered single-cycle pulses to the vending FSM.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] moneyin_raw,
  input  logic [3:0] buy_raw,
  input  logic       refund_raw,
  output logic [3:0] moneyin,
  output logic [3:0] buy,
  output logic       refund,
  output logic       pending_any
);

  logic [NUM_CHANNELS-1:0] raw_vec;
  logic [NUM_CHANNELS-1:0] rise_vec;
  logic [NUM_CHANNELS-1:0] grant;
  logic [NUM_CHANNELS-1:0] pending_q, pending_d;
  logic [NUM_CHANNELS-1:0] issue_q, issue_d;

  always_comb begin
    raw_vec            = '0;
    raw_vec[CH_REFUND] = refund_raw;
    raw_vec[CH_BUY3]   = buy_raw[3];
    raw_vec[CH_BUY2]   = buy_raw[2];
    raw_vec[CH_BUY1]   = buy_raw[1];
    raw_vec[CH_BUY0]   = buy_raw[0];
    raw_vec[CH_MONEY3] = moneyin_raw[3];
    raw_vec[CH_MONEY2] = moneyin_raw[2];
    raw_vec[CH_MONEY1] = moneyin_raw[1];
    raw_vec[CH_MONEY0] = moneyin_raw[0];
  end

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (raw_vec[i]),
      .rise    (rise_vec[i])
    );
  end

  // A rise arriving on the edge its own bit is issued re-arms it, so the second press is kept.
  always_comb begin
    grant     = first_pending(pending_q);
    pending_d = (pending_q & ~grant) | rise_vec;
    issue_d   = grant;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      issue_q   <= '0;
    end else begin
      pending_q <= pending_d;
      issue_q   <= issue_d;
    end
  end

  always_comb begin
    refund      = issue_q[CH_REFUND];
    buy         = {issue_q[CH_BUY3], issue_q[CH_BUY2], issue_q[CH_BUY1], issue_q[CH_BUY0]};
    moneyin     = {issue_q[CH_MONEY3], issue_q[CH_MONEY2], issue_q[CH_MONEY1], issue_q[CH_MONEY0]};
    pending_any = |pending_q;
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4; expected pulses are queued
// with their edge number when stimulus is applied and matched as the DUT emits them.
module tb_input_conditioner;

  logic       clk;
  logic       reset_n;
  logic [3:0] moneyin_raw;
  logic [3:0] buy_raw;
  logic       refund_raw;
  logic [3:0] moneyin;
  logic [3:0] buy;
  logic       refund;
  logic       pending_any;

  input_conditioner #(
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .moneyin_raw (moneyin_raw),
    .buy_raw     (buy_raw),
    .refund_raw  (refund_raw),
    .moneyin     (moneyin),
    .buy         (buy),
    .refund      (refund),
    .pending_any (pending_any)
  );

  typedef struct {
    int         at_edge;
    logic [8:0] vec;
  } exp_t;

  // Output vector layout {refund, buy[3:0], moneyin[3:0]}
  localparam logic [8:0] V_REFUND = 9'h100;
  localparam logic [8:0] V_BUY3   = 9'h080;
  localparam logic [8:0] V_BUY2   = 9'h040;
  localparam logic [8:0] V_BUY1   = 9'h020;
  localparam logic [8:0] V_BUY0   = 9'h010;
  localparam logic [8:0] V_MON3   = 9'h008;
  localparam logic [8:0] V_MON2   = 9'h004;
  localparam logic [8:0] V_MON0   = 9'h001;
  localparam logic [8:0] V_MON1   = 9'h002;

  exp_t sb[$];
  int   edge_n = 0;
  int   n_vec  = 0;
  int   n_miss = 0;
  int   t0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int at_edge, input logic [8:0] vec);
    exp_t e;
    e.at_edge = at_edge;
    e.vec     = vec;
    sb.push_back(e);
  endtask

  // One clock: count the rising edge, then inspect outputs at the falling edge.
  task automatic step();
    logic [8:0] outs;
    exp_t       e;
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    outs = {refund, buy, moneyin};
    check("onehot", 32'($countones(outs) <= 1), 32'd1);
    if (outs != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'(outs), 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_edge", edge_n, e.at_edge);
        check("pulse_vec", 32'(outs), 32'(e.vec));
      end
    end
  endtask

  task automatic settle(input int n);
    repeat (n) step();
    check("missing_pulse", sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    reset_n     = 1'b0;
    moneyin_raw = '0;
    buy_raw     = '0;
    refund_raw  = 1'b0;
    #1;
    check("reset_outs", 32'({refund, buy, moneyin}), 32'd0);
    check("reset_pend", 32'(pending_any), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    step();

    // Single coin, held: pulse at edge 6, pending_any only after edge 5
    t0 = edge_n + 1;
    moneyin_raw[1] = 1'b1;
    push(t0 + 6, V_MON1);
    repeat (20) begin
      step();
      check("t1_pend", 32'(pending_any), 32'(edge_n == t0 + 5));
    end
    moneyin_raw[1] = 1'b0;
    settle(10);

    // Three-sample glitch: no event
    buy_raw[0] = 1'b1;
    repeat (3) begin
      step();
      check("t2_pend", 32'(pending_any), 32'd0);
    end
    buy_raw[0] = 1'b0;
    repeat (10) begin
      step();
      check("t2_pend", 32'(pending_any), 32'd0);
    end
    settle(1);

    // Simultaneous rises resolved in priority order
    t0 = edge_n + 1;
    refund_raw     = 1'b1;
    buy_raw[2]     = 1'b1;
    moneyin_raw[3] = 1'b1;
    push(t0 + 6, V_REFUND);
    push(t0 + 7, V_BUY2);
    push(t0 + 8, V_MON3);
    repeat (12) begin
      step();
      check("t3_pend", 32'(pending_any), 32'((edge_n >= t0 + 5) && (edge_n <= t0 + 7)));
    end
    refund_raw  = 1'b0;
    buy_raw     = '0;
    moneyin_raw = '0;
    settle(10);

    // Bouncing coin then stable: one pulse 6 edges after the final rise
    t0 = edge_n + 1;
    push(t0 + 26, V_MON0);
    for (int i = 0; i < 20; i++) begin
      moneyin_raw[0] = ((i % 4) < 2);
      step();
    end
    moneyin_raw[0] = 1'b1;
    repeat (12) step();
    moneyin_raw[0] = 1'b0;
    settle(10);

    // Re-press accepted on the very edge its earlier press is issued: both pulses appear
    t0 = edge_n + 1;
    refund_raw  = 1'b1;
    buy_raw     = 4'hF;
    moneyin_raw = 4'b1100;
    push(t0 + 6,  V_REFUND);
    push(t0 + 7,  V_BUY3);
    push(t0 + 8,  V_BUY2);
    push(t0 + 9,  V_BUY1);
    push(t0 + 10, V_BUY0);
    push(t0 + 11, V_MON3);
    push(t0 + 12, V_MON2);
    push(t0 + 13, V_MON0);
    push(t0 + 14, V_MON0);
    for (int i = 0; i < 8; i++) begin
      moneyin_raw[0] = (i < 4);
      step();
    end
    moneyin_raw[0] = 1'b1;
    repeat (10) step();
    refund_raw  = 1'b0;
    buy_raw     = '0;
    moneyin_raw = '0;
    settle(12);

    // Reset mid-debounce with the button held: latency restarts after release
    t0 = edge_n + 1;
    buy_raw[3] = 1'b1;
    repeat (3) step();
    reset_n = 1'b0;
    #1;
    check("t6_rst_outs", 32'({refund, buy, moneyin}), 32'd0);
    check("t6_rst_pend", 32'(pending_any), 32'd0);
    repeat (2) step();
    reset_n = 1'b1;
    push(edge_n + 1 + 6, V_BUY3);
    repeat (12) step();
    buy_raw[3] = 1'b0;
    settle(10);

    // Reset while a pulse is out and two events still pending: all discarded at once
    t0 = edge_n + 1;
    refund_raw     = 1'b1;
    buy_raw[2]     = 1'b1;
    moneyin_raw[3] = 1'b1;
    push(t0 + 6, V_REFUND);
    repeat (7) step();
    check("t7_pend_before", 32'(pending_any), 32'd1);
    reset_n        = 1'b0;
    refund_raw     = 1'b0;
    buy_raw[2]     = 1'b0;
    moneyin_raw[3] = 1'b0;
    #1;
    check("t7_rst_outs", 32'({refund, buy, moneyin}), 32'd0);
    check("t7_rst_pend", 32'(pending_any), 32'd0);
    repeat (3) step();
    reset_n = 1'b1;
    repeat (12) begin
      step();
      check("t7_pend_after", 32'(pending_any), 32'd0);
    end
    settle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, SHALL set the number of consecutive stable synchronized samples required to accept a level change (legal range 2..2^24).
REQ-002 Clock SHALL be one clock; reset SHALL be asynchronous and active-low.
REQ-003 Port: clk  input  1  system clock; all state is updated on its rising edge.
REQ-004 Port: reset_n  input  1  asynchronous active-low reset.
REQ-005 Port: moneyin_raw  input  4  raw coin switches, unsynchronized (1000[3], 500[2], 200[1], 100[0]).
REQ-006 Port: buy_raw  input  4  raw product buttons, unsynchronized (900[3], 700[2], 500[1], 300[0]).
REQ-007 Port: refund_raw  input  1  raw refund button, unsynchronized.
REQ-008 Port: moneyin  output  4  single-cycle coin event pulses to the vending FSM.
REQ-009 Port: buy  output  4  single-cycle buy event pulses to the vending FSM.
REQ-010 Port: refund  output  1  single-cycle refund event pulse to the vending FSM.
REQ-011 Port: pending_any  output  1  high while one or more accepted events await issue.

Function
REQ-012 Each of the 9 channels SHALL pass its raw input through a two-flop synchronizer before any other logic.
REQ-013 Per channel: counter SHALL increment on each edge where sync output differs from the debounced level; it SHALL clear on any edge where they are equal.
REQ-014 Debounced level SHALL flip, and the counter SHALL clear, on the edge where the counter equals DEBOUNCE_CYCLES-1 and the sync output still differs.
REQ-015 Counter width SHALL be ceil(log2(DEBOUNCE_CYCLES)); it SHALL never wrap.
REQ-016 A 0->1 debounced flip SHALL set that channel's pending bit on the same edge; a 1->0 flip SHALL produce no event.
REQ-017 A pending bit already set SHALL absorb a further rise (coalesce; one pulse only).
REQ-018 Arbiter: each edge, if any pending bit is set, the highest-priority one SHALL be issued as a registered one-cycle pulse on its output bit and cleared.
REQ-019 Priority order, high to low: refund, buy[3], buy[2], buy[1], buy[0], moneyin[3], moneyin[2], moneyin[1], moneyin[0].
REQ-020 At most one of the 9 output bits SHALL be high in any cycle; no output SHALL be high two consecutive cycles for the same accepted event.
REQ-021 If a channel's pending bit is being issued on the same edge its new rise is accepted, set SHALL win (bit stays pending, second pulse follows).
REQ-022 Latency: raw rise first sampled at edge 0, held stable -> pending set at edge DEBOUNCE_CYCLES+1, pulse high from edge DEBOUNCE_CYCLES+2 for one cycle when no higher-priority bit is pending.
REQ-023 A raw glitch shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no pulse.
REQ-024 pending_any SHALL equal the OR of all pending bits (registered state, no combinational path from raw inputs).

Reset
REQ-025 reset_n low SHALL clear synchronizers, counters, debounced levels, pending bits and all outputs to 0 immediately, independent of clk.
REQ-026 Reset mid-debounce or with events pending SHALL discard them; a button held through reset release SHALL yield exactly one pulse, with REQ-022 latency measured from the first post-release edge.

Structure
REQ-027 Shared package SHALL hold the DEBOUNCE_CYCLES default, channel count (9) and channel index constants for refund/buy/moneyin in priority order.
REQ-028 Synchronizer, counter, debounced level and rise detect SHALL be one sub-module, debounce_channel, instantiated 9 times; pending bits and arbiter SHALL reside in input_conditioner.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 moneyin_raw[1] high at edge 0, held 20 cycles -> moneyin=4'b0010 during cycle after edge 6 only; pending_any high cycle after edge 5 only.
REQ-030 buy_raw[0] high for 3 edges then low -> no output pulse, pending_any stays 0.
REQ-031 refund_raw, buy_raw[2], moneyin_raw[3] rise at edge 0 together -> refund after edge 6, buy[2] after edge 7, moneyin[3] after edge 8, one bit per cycle.
REQ-032 moneyin_raw[0] toggles 1/0 every 2 cycles for 20 cycles then held high -> exactly one moneyin[0] pulse, 6 edges after the final stable rise.
REQ-033 buy_raw[3] held high, reset_n pulsed low mid-debounce at edge 3 and released -> all outputs 0 during reset, one buy[3] pulse 6 edges after first post-release edge.
